// File: rtl/dpe_pkg.sv
// Shared types and helpers for the dot-product engine: FSM encoding,
// index-width calculation and accumulator bound helpers.
package dpe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest accumulator the bound helpers can describe.
    localparam int MAX_ACC_W = 64;

    // Element index width; at least one bit even for tiny vectors.
    function automatic int calc_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest representable accumulator value of width w (low w bits valid).
    function automatic logic [MAX_ACC_W-1:0] acc_max(input int w, input bit sgn);
        return sgn ? ({MAX_ACC_W{1'b1}} >> (MAX_ACC_W - w + 1))
                   : ({MAX_ACC_W{1'b1}} >> (MAX_ACC_W - w));
    endfunction

    // Smallest representable accumulator value of width w (low w bits valid).
    function automatic logic [MAX_ACC_W-1:0] acc_min(input int w, input bit sgn);
        return sgn ? ({{(MAX_ACC_W-1){1'b0}}, 1'b1} << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// Operand write / readback / compute handshake bundle for the engine.
interface dot_product_engine_if #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 16
);
    localparam int IDX_W = dpe_pkg::calc_idx_w(VEC_LEN);

    logic              wr_en;
    logic              wr_sel;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              rd_sel;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              loaded;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [ACC_W-1:0]  result;
    logic              overflow;

    modport master (
        output wr_en, wr_sel, wr_idx, wr_data, start, rd_sel, rd_idx,
        input  rd_data, loaded, busy, done, result_valid, result, overflow
    );

    modport slave (
        input  wr_en, wr_sel, wr_idx, wr_data, start, rd_sel, rd_idx,
        output rd_data, loaded, busy, done, result_valid, result, overflow
    );
endinterface

// File: rtl/dot_product_engine_mac_step.sv
// One combinational multiply-accumulate step with overflow detection.
// In freeze mode an overflowing step returns the old accumulator; in
// saturate mode it clamps toward the side that overflowed.
module mac_step
    import dpe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  next_acc,
    output logic              ovf
);
    localparam int PW  = 2 * DATA_W;
    localparam int EXT = ACC_W + 1 - PW;

    localparam logic [MAX_ACC_W-1:0] MAX_FULL = acc_max(ACC_W, SIGNED != 0);
    localparam logic [MAX_ACC_W-1:0] MIN_FULL = acc_min(ACC_W, SIGNED != 0);
    localparam logic [ACC_W-1:0]     MAX_V    = MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     MIN_V    = MIN_FULL[ACC_W-1:0];

    logic [PW-1:0] a_x, b_x, prod;
    logic [ACC_W:0] prod_x, acc_x, sum;

    // Extend operands, multiply, widen by one bit and add; the low 2*DATA_W
    // bits of the product are correct for both signednesses.
    always_comb begin
        a_x    = (SIGNED != 0) ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        b_x    = (SIGNED != 0) ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        prod   = a_x * b_x;
        prod_x = (SIGNED != 0) ? {{EXT{prod[PW-1]}}, prod} : {{EXT{1'b0}}, prod};
        acc_x  = (SIGNED != 0) ? {acc[ACC_W-1], acc} : {1'b0, acc};
        sum    = acc_x + prod_x;
        ovf    = (SIGNED != 0) ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        if (!ovf)
            next_acc = sum[ACC_W-1:0];
        else if (SATURATE == 0)
            next_acc = acc;
        else if ((SIGNED != 0) && sum[ACC_W])
            next_acc = MIN_V;
        else
            next_acc = MAX_V;
    end
endmodule

// File: rtl/dot_product_engine.sv
// Vector dot-product engine: two indexed operand register files, a
// written-bit mask per vector, and an IDLE/RUN/DONE sequencer that
// performs one MAC per cycle.
module dot_product_engine
    import dpe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int VEC_LEN  = 4,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    dot_product_engine_if.slave bus
);
    localparam int               IDX_W = calc_idx_w(VEC_LEN);
    localparam logic [IDX_W:0]   LEN   = (IDX_W+1)'(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(VEC_LEN - 1);

    logic [VEC_LEN-1:0][DATA_W-1:0] vec_a, vec_b;
    logic [VEC_LEN-1:0]             wr_a, wr_b;

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] acc, mac_acc;
    logic             mac_ovf;
    logic             overflow_q, done_q, busy_q, rv_q;
    logic             loaded, wr_ok, start_ok;

    assign loaded   = (&wr_a) & (&wr_b);
    assign wr_ok    = bus.wr_en && !busy_q && ({1'b0, bus.wr_idx} < LEN);
    // Judged on pre-write loaded, so a completing write never self-starts.
    assign start_ok = bus.start && loaded && !busy_q;

    mac_step #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_mac (
        .acc      (acc),
        .a        (vec_a[idx]),
        .b        (vec_b[idx]),
        .next_acc (mac_acc),
        .ovf      (mac_ovf)
    );

    // Operand register files and their written-bit masks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_a <= '0;
            vec_b <= '0;
            wr_a  <= '0;
            wr_b  <= '0;
        end else if (clr) begin
            vec_a <= '0;
            vec_b <= '0;
            wr_a  <= '0;
            wr_b  <= '0;
        end else if (wr_ok) begin
            if (bus.wr_sel) begin
                vec_b[bus.wr_idx] <= bus.wr_data;
                wr_b[bus.wr_idx]  <= 1'b1;
            end else begin
                vec_a[bus.wr_idx] <= bus.wr_data;
                wr_a[bus.wr_idx]  <= 1'b1;
            end
        end
    end

    // Sequencer and accumulator; status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
        end else if (clr) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok)
                        rv_q <= 1'b0;
                    if (start_ok) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        idx        <= '0;
                        acc        <= '0;
                        overflow_q <= 1'b0;
                        rv_q       <= 1'b0;
                    end
                end
                RUN: begin
                    // Once frozen, later steps elapse without touching acc.
                    if ((SATURATE != 0) || !overflow_q) begin
                        acc <= mac_acc;
                        if (mac_ovf)
                            overflow_q <= 1'b1;
                    end
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        rv_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (wr_ok) begin
                        state <= IDLE;
                        rv_q  <= 1'b0;
                    end else if (start_ok) begin
                        state      <= RUN;
                        busy_q     <= 1'b1;
                        idx        <= '0;
                        acc        <= '0;
                        overflow_q <= 1'b0;
                        rv_q       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data      = ({1'b0, bus.rd_idx} < LEN)
                              ? (bus.rd_sel ? vec_b[bus.rd_idx] : vec_a[bus.rd_idx])
                              : '0;
    assign bus.loaded       = loaded;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = rv_q;
    assign bus.result       = acc;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// Drives four engines (unsigned/signed x freeze/saturate) with one common
// stimulus stream and checks them against an integer reference model.
module tb_dot_product_engine;
    localparam int DATA_W  = 8;
    localparam int VEC_LEN = 4;
    localparam int ACC_W   = 16;
    localparam int NCFG    = 4;

    logic       clk = 1'b0;
    logic       rst_n, clr, wr_en, wr_sel, start, rd_sel;
    logic [1:0] wr_idx, rd_idx;
    logic [7:0] wr_data;

    logic [15:0] res_v  [NCFG];
    logic [7:0]  rd_v   [NCFG];
    logic        ovf_v  [NCFG];
    logic        busy_v [NCFG];
    logic        done_v [NCFG];
    logic        rv_v   [NCFG];
    logic        ld_v   [NCFG];

    int errors = 0;
    int checks = 0;
    int ma [VEC_LEN];
    int mb [VEC_LEN];

    always #5 clk = ~clk;

    // cfg index: bit1 = SIGNED, bit0 = SATURATE
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        dot_product_engine_if #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) bus ();
        assign bus.wr_en   = wr_en;
        assign bus.wr_sel  = wr_sel;
        assign bus.wr_idx  = wr_idx;
        assign bus.wr_data = wr_data;
        assign bus.start   = start;
        assign bus.rd_sel  = rd_sel;
        assign bus.rd_idx  = rd_idx;
        assign res_v[g]  = bus.result;
        assign rd_v[g]   = bus.rd_data;
        assign ovf_v[g]  = bus.overflow;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign rv_v[g]   = bus.result_valid;
        assign ld_v[g]   = bus.loaded;
        dot_product_engine #(
            .DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W),
            .SIGNED(g / 2), .SATURATE(g % 2)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .bus   (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference: integer dot product with range bounds; returns final result
    // (16-bit) and index of the first overflowing step (-1 if none).
    function automatic void model(input int sgn, input int sat, output int res, output int first_ovf);
        longint acc, p, s, hi, lo;
        bit frozen;
        acc = 0; frozen = 0; first_ovf = -1;
        hi = sgn ? 32767 : 65535;
        lo = sgn ? -32768 : 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (!frozen) begin
                p = sgn ? longint'(sx(ma[i])) * longint'(sx(mb[i])) : longint'(ma[i]) * longint'(mb[i]);
                s = acc + p;
                if (s > hi || s < lo) begin
                    if (first_ovf < 0) first_ovf = i;
                    if (sat) acc = (s > hi) ? hi : lo;
                    else     frozen = 1;
                end else begin
                    acc = s;
                end
            end
        end
        res = int'(acc) & 32'hFFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input bit sel, input int i, input int d);
        wr_en = 1'b1; wr_sel = sel; wr_idx = 2'(i); wr_data = 8'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < VEC_LEN; i++) write(1'b0, i, ma[i]);
        for (int i = 0; i < VEC_LEN; i++) write(1'b1, i, mb[i]);
    endtask

    // Start one run and check busy/done/overflow cycle by cycle, then results.
    // poke drives a write during the busy cycles, which must be ignored.
    task automatic run_check(input string tag, input bit poke);
        int r [NCFG];
        int fo [NCFG];
        bit exp_ovf;
        for (int c = 0; c < NCFG; c++) model(c / 2, c % 2, r[c], fo[c]);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " busy@start"}, 32'(busy_v[0]), 32'd1);
        chk({tag, " rv@start"}, 32'(rv_v[0]), 32'd0);
        for (int c = 0; c < NCFG; c++)
            chk($sformatf("%s ovf@start c%0d", tag, c), 32'(ovf_v[c]), 32'd0);
        if (poke) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = 8'hAA;
        end
        for (int j = 1; j <= VEC_LEN; j++) begin
            if (j == VEC_LEN) wr_en = 1'b0;
            step();
            for (int c = 0; c < NCFG; c++) begin
                exp_ovf = (fo[c] >= 0) && (j - 1 >= fo[c]);
                chk($sformatf("%s ovf c%0d j%0d", tag, c, j), 32'(ovf_v[c]), 32'(exp_ovf));
            end
            if (j < VEC_LEN) begin
                chk($sformatf("%s busy j%0d", tag, j), 32'(busy_v[0]), 32'd1);
                chk($sformatf("%s done j%0d", tag, j), 32'(done_v[0]), 32'd0);
            end
        end
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("%s busy_end c%0d", tag, c), 32'(busy_v[c]), 32'd0);
            chk($sformatf("%s done c%0d", tag, c), 32'(done_v[c]), 32'd1);
            chk($sformatf("%s rv c%0d", tag, c), 32'(rv_v[c]), 32'd1);
            chk($sformatf("%s result c%0d", tag, c), 32'(res_v[c]), 32'(r[c]));
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy_v[c]), 32'd0);
            chk($sformatf("%s done c%0d", tag, c), 32'(done_v[c]), 32'd0);
            chk($sformatf("%s loaded c%0d", tag, c), 32'(ld_v[c]), 32'd0);
            chk($sformatf("%s rv c%0d", tag, c), 32'(rv_v[c]), 32'd0);
            chk($sformatf("%s result c%0d", tag, c), 32'(res_v[c]), 32'd0);
            chk($sformatf("%s ovf c%0d", tag, c), 32'(ovf_v[c]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = '0;
        wr_data = '0; start = 1'b0; rd_sel = 1'b0; rd_idx = '0;
        step(); step();
        check_cleared("reset");
        chk("reset rd_data", 32'(rd_v[0]), 32'd0);
        rst_n = 1'b1;
        step();

        // Partial load: start must be ignored
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        for (int i = 0; i < 3; i++) write(1'b0, i, ma[i]);
        for (int i = 0; i < VEC_LEN; i++) write(1'b1, i, mb[i]);
        chk("partial loaded", 32'(ld_v[0]), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        chk("partial busy", 32'(busy_v[0]), 32'd0);
        step();
        chk("partial done", 32'(done_v[0]), 32'd0);

        // Completing write with start in the same cycle: no start
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd3; wr_data = 8'd4; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("wr+start busy", 32'(busy_v[0]), 32'd0);
        chk("wr+start loaded", 32'(ld_v[0]), 32'd1);
        step();
        chk("wr+start busy2", 32'(busy_v[0]), 32'd0);
        chk("wr+start done2", 32'(done_v[0]), 32'd0);

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < VEC_LEN; i++) begin
                rd_sel = 1'(s); rd_idx = 2'(i);
                #1;
                chk($sformatf("readback s%0d i%0d", s, i), 32'(rd_v[0]), 32'(s ? mb[i] : ma[i]));
            end

        run_check("base", 1'b1);
        chk("base result", 32'(res_v[0]), 32'h46);
        rd_sel = 1'b0; rd_idx = 2'd0;
        #1;
        chk("busy write ignored", 32'(rd_v[0]), 32'd1);
        step();
        chk("done pulse width", 32'(done_v[0]), 32'd0);
        chk("rv holds", 32'(rv_v[0]), 32'd1);

        // Write in DONE drops result_valid
        write(1'b0, 2, 0);
        ma[2] = 0;
        for (int c = 0; c < NCFG; c++)
            chk($sformatf("rv drop c%0d", c), 32'(rv_v[c]), 32'd0);
        run_check("a2zero", 1'b0);
        chk("a2zero result", 32'(res_v[0]), 32'h31);
        run_check("b2b", 1'b0);

        // Write and start in DONE: write wins
        wr_en = 1'b1; wr_sel = 1'b0; wr_idx = 2'd0; wr_data = 8'd1; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("done wr+start busy", 32'(busy_v[0]), 32'd0);
        chk("done wr+start rv", 32'(rv_v[0]), 32'd0);
        step();
        chk("done wr+start busy2", 32'(busy_v[0]), 32'd0);

        ma = '{255, 255, 255, 255};
        mb = '{255, 255, 255, 255};
        load_all();
        run_check("ff", 1'b0);
        chk("ff freeze", 32'(res_v[0]), 32'hFE01);
        chk("ff sat", 32'(res_v[1]), 32'hFFFF);

        ma = '{128, 128, 128, 128};
        mb = '{128, 128, 128, 128};
        load_all();
        run_check("x80", 1'b0);
        chk("x80 s freeze", 32'(res_v[2]), 32'h4000);
        chk("x80 s sat", 32'(res_v[3]), 32'h7FFF);

        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                ma[i] = ($urandom % 2) ? int'($urandom_range(180, 255)) : int'($urandom_range(0, 255));
                mb[i] = ($urandom % 2) ? int'($urandom_range(180, 255)) : int'($urandom_range(0, 255));
            end
            load_all();
            run_check($sformatf("rnd%0d", n), 1'b0);
        end

        // clr after two MAC steps
        ma = '{1, 2, 3, 4};
        mb = '{5, 6, 7, 8};
        load_all();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        clr = 1'b1; step(); clr = 1'b0;
        check_cleared("clr");
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < VEC_LEN; i++) begin
                rd_sel = 1'(s); rd_idx = 2'(i);
                #1;
                chk($sformatf("clr rd s%0d i%0d", s, i), 32'(rd_v[0]), 32'd0);
            end
        for (int j = 0; j < VEC_LEN; j++) begin
            step();
            chk($sformatf("clr no done %0d", j), 32'(done_v[0]), 32'd0);
        end

        // Asynchronous reset mid-run
        load_all();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check_cleared("arst");
        rst_n = 1'b1;
        step();
        chk("arst busy after", 32'(busy_v[0]), 32'd0);
        chk("arst done after", 32'(done_v[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
